ste_master: RTL and testbench

- STEbus initiator (bus master) in the MIO CPLD. Turns single-byte local requests from the Z180-side logic into STEbus memory or I/O cycles.
- Cycle sequence: drives ADR/CM, asserts ADRSTB*, then DATSTB*. Waits for the responder's DATACK* or TRANSERR*, releases the strobes, and completes.
- A timeout guards against absent responders.
- This block is the counterpart of the slave-side DATACK* generator already on the bus.

---
 rtl/ste_pkg.sv | 25 ++
 rtl/ste_sync.sv | 25 ++
 rtl/ste_master.sv | 163 ++++++++++++++++
 tb/tb_ste_master.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ste_pkg.sv
// Shared types and constants for the STEbus initiator.
// State encoding, command-modifier values and the default timeout.
package ste_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [2:0] CM_MEM_RD = 3'b111;
  localparam logic [2:0] CM_MEM_WR = 3'b110;
  localparam logic [2:0] CM_IO_RD  = 3'b011;
  localparam logic [2:0] CM_IO_WR  = 3'b010;

  localparam int TIMEOUT_DEFAULT = 255;

  // CM2 selects memory space, CM0 selects read; CM1 is always set.
  function automatic logic [2:0] cm_encode(input logic io, input logic we);
    return {~io, 1'b1, ~we};
  endfunction

endpackage

// File: rtl/ste_sync.sv
// Two-flop synchronizer for active-low bus inputs; both flops reset to
// the inactive level (1).
module ste_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ste_master.sv
// STEbus initiator: converts one local byte request into a single STEbus
// memory or I/O cycle, with a timeout for absent or stuck responders.
module ste_master
  import ste_pkg::*;
#(
  parameter int ADDR_SETUP = 1,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        io,
  input  logic [19:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [19:0] ste_adr,
  output logic [2:0]  ste_cm,
  output logic        ste_adrstb_n,
  output logic        ste_datstb_n,
  output logic [7:0]  ste_d_out,
  output logic        ste_d_oe,
  input  logic [7:0]  ste_d_in,
  input  logic        ste_datack_n,
  input  logic        ste_transerr_n,
  output logic [2:0]  dbg_state
);

  localparam logic [7:0] SETUP_LAST = 8'(ADDR_SETUP - 1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_err_pend;
  logic        r_we;
  logic [7:0]  r_rdata;
  logic [19:0] r_adr;
  logic [2:0]  r_cm;
  logic        r_adrstb_n;
  logic        r_datstb_n;
  logic [7:0]  r_d_out;
  logic        r_d_oe;
  logic        w_datack_s;
  logic        w_transerr_s;
  logic        w_set_err;

  ste_sync u_sync_datack (
    .clk   (clk),
    .reset (reset),
    .i_d   (ste_datack_n),
    .o_q   (w_datack_s)
  );

  ste_sync u_sync_transerr (
    .clk   (clk),
    .reset (reset),
    .i_d   (ste_transerr_n),
    .o_q   (w_transerr_s)
  );

  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    case (r_state)
      ST_IDLE: if (req) w_next = ST_ADDR;
      ST_ADDR: if (r_cnt == SETUP_LAST) w_next = ST_DATA;
      ST_DATA: begin
        // An acknowledge wins over a lone TRANSERR*; both together is an error.
        if (!w_datack_s) begin
          w_next    = ST_RELEASE;
          w_set_err = ~w_transerr_s;
        end else if (!w_transerr_s || r_cnt == TO_LAST) begin
          w_next    = ST_RELEASE;
          w_set_err = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (w_datack_s && w_transerr_s) begin
          w_next = ST_DONE;
        end else if (r_cnt == TO_LAST) begin
          w_next    = ST_DONE;
          w_set_err = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_err_pend <= 1'b0;
      r_we       <= 1'b0;
      r_rdata    <= 8'd0;
      r_adr      <= 20'd0;
      r_cm       <= 3'b000;
      r_adrstb_n <= 1'b1;
      r_datstb_n <= 1'b1;
      r_d_out    <= 8'd0;
      r_d_oe     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_err) r_err_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= 8'd0;
          if (req) begin
            r_we       <= we;
            r_adr      <= addr;
            r_cm       <= cm_encode(io, we);
            r_d_out    <= wdata;
            r_d_oe     <= we;
            r_adrstb_n <= 1'b0;
            r_err_pend <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (w_next == ST_DATA) begin
            r_cnt      <= 8'd0;
            r_datstb_n <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DATA: begin
          if (w_next == ST_RELEASE) begin
            r_cnt      <= 8'd0;
            r_adrstb_n <= 1'b1;
            r_datstb_n <= 1'b1;
            r_d_oe     <= 1'b0;
            if (!w_datack_s && !r_we) r_rdata <= ste_d_in;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_RELEASE: begin
          if (w_next == ST_DONE) r_cnt <= 8'd0;
          else                   r_cnt <= r_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign err          = (r_state == ST_DONE) & r_err_pend;
  assign rdata        = r_rdata;
  assign ste_adr      = r_adr;
  assign ste_cm       = r_cm;
  assign ste_adrstb_n = r_adrstb_n;
  assign ste_datstb_n = r_datstb_n;
  assign ste_d_out    = r_d_out;
  assign ste_d_oe     = r_d_oe;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_ste_master.sv
// Directed bench for ste_master with a simple STEbus responder model.
module tb_ste_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0, io = 1'b0;
  logic [19:0] addr = 20'd0;
  logic [7:0]  wdata = 8'd0;
  logic        busy, done, err;
  logic [7:0]  rdata;
  logic [19:0] ste_adr;
  logic [2:0]  ste_cm;
  logic        ste_adrstb_n, ste_datstb_n, ste_d_oe;
  logic [7:0]  ste_d_out;
  logic [7:0]  ste_d_in = 8'd0;
  logic        ste_datack_n = 1'b1, ste_transerr_n = 1'b1;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // responder model controls
  logic       resp_en   = 1'b1;
  logic       resp_terr = 1'b0;
  int         resp_k    = 3;
  logic [7:0] resp_data = 8'd0;

  // observations of the last transaction
  logic        obs_done, obs_err, obs_oe_bad, obs_rel_at_done;
  logic [19:0] obs_adr;
  logic [2:0]  obs_cm;
  logic [7:0]  obs_dout;
  int          obs_lo_cycles;

  ste_master dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .we             (we),
    .io             (io),
    .addr           (addr),
    .wdata          (wdata),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .rdata          (rdata),
    .ste_adr        (ste_adr),
    .ste_cm         (ste_cm),
    .ste_adrstb_n   (ste_adrstb_n),
    .ste_datstb_n   (ste_datstb_n),
    .ste_d_out      (ste_d_out),
    .ste_d_oe       (ste_d_oe),
    .ste_d_in       (ste_d_in),
    .ste_datack_n   (ste_datack_n),
    .ste_transerr_n (ste_transerr_n),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #31 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder: acks resp_k cycles after seeing DATSTB*, releases one cycle
  // after DATSTB* negates.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && !ste_datstb_n && ste_datack_n) begin
        repeat (resp_k - 1) @(negedge clk);
        ste_datack_n   = 1'b0;
        ste_transerr_n = ~resp_terr;
        ste_d_in       = resp_data;
        for (int i = 0; i < 600 && !ste_datstb_n; i++) @(negedge clk);
        @(negedge clk);
        ste_datack_n   = 1'b1;
        ste_transerr_n = 1'b1;
        ste_d_in       = 8'd0;
      end
    end
  end

  // driver: one request, then follow it to done
  task automatic run_txn(input logic t_we, input logic t_io, input logic [19:0] t_addr,
                         input logic [7:0] t_wdata);
    obs_done = 1'b0; obs_err = 1'b0; obs_oe_bad = 1'b0; obs_rel_at_done = 1'b0;
    obs_lo_cycles = 0;
    @(negedge clk);
    req = 1'b1; we = t_we; io = t_io; addr = t_addr; wdata = t_wdata;
    @(negedge clk);
    req = 1'b0;
    obs_adr = ste_adr; obs_cm = ste_cm; obs_dout = ste_d_out;
    for (int i = 0; i < 2000; i++) begin
      if (!ste_datstb_n) begin
        obs_lo_cycles++;
        if (ste_d_oe !== t_we) obs_oe_bad = 1'b1;
      end
      if (done) begin
        obs_done = 1'b1;
        obs_err  = err;
        obs_rel_at_done = ste_adrstb_n & ste_datstb_n & ~ste_d_oe;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic        saw_done;
    logic        reached;
    int          n_done, n_adr, gap;
    logic        prev_adrstb;

    // reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy",   32'(busy), 32'd0);
    check_eq("rst_done",   32'(done), 32'd0);
    check_eq("rst_err",    32'(err), 32'd0);
    check_eq("rst_rdata",  32'(rdata), 32'd0);
    check_eq("rst_adrstb", 32'(ste_adrstb_n), 32'd1);
    check_eq("rst_datstb", 32'(ste_datstb_n), 32'd1);
    check_eq("rst_oe",     32'(ste_d_oe), 32'd0);
    check_eq("rst_adr",    32'(ste_adr), 32'd0);
    check_eq("rst_cm",     32'(ste_cm), 32'd0);
    check_eq("rst_dout",   32'(ste_d_out), 32'd0);
    check_eq("rst_state",  32'(dbg_state), 32'd0);

    // memory write
    run_txn(1'b1, 1'b0, 20'h12345, 8'hA5);
    check_eq("mw_cm",    32'(obs_cm), 32'b110);
    check_eq("mw_adr",   32'(obs_adr), 32'h12345);
    check_eq("mw_dout",  32'(obs_dout), 32'hA5);
    check_eq("mw_oe",    32'(obs_oe_bad), 32'd0);
    check_eq("mw_done",  32'(obs_done), 32'd1);
    check_eq("mw_err",   32'(obs_err), 32'd0);
    check_eq("mw_rel",   32'(obs_rel_at_done), 32'd1);

    // I/O read
    resp_data = 8'h3C;
    run_txn(1'b0, 1'b1, 20'h000F0, 8'h00);
    check_eq("ior_cm",    32'(obs_cm), 32'b011);
    check_eq("ior_adr",   32'(obs_adr), 32'h000F0);
    check_eq("ior_oe",    32'(obs_oe_bad), 32'd0);
    check_eq("ior_done",  32'(obs_done), 32'd1);
    check_eq("ior_rdata", 32'(rdata), 32'h3C);
    check_eq("ior_err",   32'(obs_err), 32'd0);

    // memory read, absent responder
    resp_en = 1'b0;
    run_txn(1'b0, 1'b0, 20'h54321, 8'h00);
    check_eq("to_cm",     32'(obs_cm), 32'b111);
    check_eq("to_lo",     32'(obs_lo_cycles), 32'd255);
    check_eq("to_done",   32'(obs_done), 32'd1);
    check_eq("to_err",    32'(obs_err), 32'd1);
    check_eq("to_rdata",  32'(rdata), 32'h3C);
    check_eq("to_rel",    32'(obs_rel_at_done), 32'd1);
    resp_en = 1'b1;

    // TRANSERR* together with DATACK* on a read
    resp_terr = 1'b1; resp_data = 8'h77;
    run_txn(1'b0, 1'b0, 20'h00ABC, 8'h00);
    check_eq("te_done", 32'(obs_done), 32'd1);
    check_eq("te_err",  32'(obs_err), 32'd1);
    check_eq("te_rel",  32'(obs_rel_at_done), 32'd1);
    resp_terr = 1'b0;
    repeat (4) @(negedge clk);

    // reset while in DATA
    resp_en = 1'b0;
    saw_done = 1'b0; reached = 1'b0;
    req = 1'b1; we = 1'b1; io = 1'b1; addr = 20'h0BEEF; wdata = 8'h5A;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done) saw_done = 1'b1;
      if (dbg_state == 3'd2) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("mr_reach_data", 32'(reached), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    if (done) saw_done = 1'b1;
    check_eq("mr_datstb", 32'(ste_datstb_n), 32'd1);
    check_eq("mr_adrstb", 32'(ste_adrstb_n), 32'd1);
    check_eq("mr_oe",     32'(ste_d_oe), 32'd0);
    check_eq("mr_busy",   32'(busy), 32'd0);
    check_eq("mr_nodone", 32'(saw_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    resp_en = 1'b1;
    run_txn(1'b1, 1'b1, 20'h00042, 8'h99);
    check_eq("mr_next_cm",   32'(obs_cm), 32'b010);
    check_eq("mr_next_done", 32'(obs_done), 32'd1);
    check_eq("mr_next_err",  32'(obs_err), 32'd0);
    repeat (4) @(negedge clk);

    // back-to-back writes with req held high
    n_done = 0; n_adr = 0; gap = 0; prev_adrstb = 1'b1;
    req = 1'b1; we = 1'b1; io = 1'b0; addr = 20'h00001; wdata = 8'h11;
    for (int i = 0; i < 2000 && n_done < 2; i++) begin
      @(negedge clk);
      if (busy && n_adr == 0) begin addr = 20'h00002; wdata = 8'h22; end
      if (prev_adrstb && !ste_adrstb_n) begin
        n_adr++;
        if (n_adr == 2) begin
          check_eq("b2b_ack_released", 32'(ste_datack_n), 32'd1);
          check_eq("b2b_adr2",  32'(ste_adr), 32'h00002);
          check_eq("b2b_dout2", 32'(ste_d_out), 32'h22);
          req = 1'b0;
        end
      end
      prev_adrstb = ste_adrstb_n;
      if (n_done == 1 && !busy) gap++;
      if (done) begin
        n_done++;
        check_eq("b2b_err", 32'(err), 32'd0);
      end
    end
    req = 1'b0;
    check_eq("b2b_dones", 32'(n_done), 32'd2);
    check_eq("b2b_gap",   32'(gap), 32'd1);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
